card_match_ctrl: RTL



---
 rtl/card_match_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/card_match_ctrl.sv
// Card-flip match game controller: requests a shuffled 16-card layout, validates it,
// then tracks picks, face-up/matched masks, move count and win.
module card_match_ctrl #(
    parameter int SHOW_CYCLES = 4,
    parameter int MOVE_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              new_game,
    output logic              shuf_start,
    input  logic              shuf_done,
    input  logic [0:47]       shuf_num,
    input  logic              pick_valid,
    input  logic [3:0]        pick_idx,
    output logic [15:0]       face_up,
    output logic [15:0]       matched,
    output logic [2:0]        pick_val,
    output logic              match,
    output logic              mismatch,
    output logic              game_over,
    output logic              layout_err,
    output logic [MOVE_W-1:0] move_count,
    output logic              busy
);
    localparam int CNT_W = $clog2(SHOW_CYCLES + 1);

    typedef enum logic [3:0] {
        IDLE, REQ, CHECK, GAP, PICK1, PICK2, EVAL, SHOW, WIN
    } state_t;

    state_t             state_q, state_d;
    logic [0:47]        layout_q, layout_d;
    logic [15:0]        face_q, face_d, matched_q, matched_d;
    logic [2:0]         pick_val_q, pick_val_d;
    logic               match_q, match_d, err_q, err_d;
    logic [MOVE_W-1:0]  moves_q, moves_d;
    logic [3:0]         first_q, first_d, second_q, second_d;
    logic [CNT_W-1:0]   show_cnt_q, show_cnt_d;

    logic [2:0]  cards [16];
    logic [4:0]  cnt;
    logic        layout_ok, pick_ok;
    logic [15:0] pick_bit, first_bit, second_bit;

    // Card i occupies layout bits [3i:3i+2], MSB at the lower index.
    always_comb begin
        for (int i = 0; i < 16; i++) cards[i] = layout_q[3*i +: 3];
        layout_ok = 1'b1;
        cnt       = '0;
        for (int v = 0; v < 8; v++) begin
            cnt = '0;
            for (int k = 0; k < 16; k++)
                if (cards[k] == 3'(v)) cnt = cnt + 5'd1;
            if (cnt != 5'd2) layout_ok = 1'b0;
        end
    end

    assign pick_ok    = pick_valid && !face_q[pick_idx];
    assign pick_bit   = 16'(1) << pick_idx;
    assign first_bit  = 16'(1) << first_q;
    assign second_bit = 16'(1) << second_q;

    always_comb begin
        state_d    = state_q;
        layout_d   = layout_q;
        face_d     = face_q;
        matched_d  = matched_q;
        pick_val_d = pick_val_q;
        match_d    = 1'b0;
        err_d      = 1'b0;
        moves_d    = moves_q;
        first_d    = first_q;
        second_d   = second_q;
        show_cnt_d = show_cnt_q;
        case (state_q)
            IDLE: ;
            REQ: if (shuf_done) begin
                layout_d = shuf_num;
                state_d  = CHECK;
            end
            CHECK: if (layout_ok) begin
                face_d    = '0;
                matched_d = '0;
                moves_d   = '0;
                state_d   = PICK1;
            end else begin
                err_d   = 1'b1;
                state_d = GAP;
            end
            GAP: state_d = REQ;
            PICK1: if (pick_ok) begin
                face_d     = face_q | pick_bit;
                first_d    = pick_idx;
                pick_val_d = cards[pick_idx];
                state_d    = PICK2;
            end
            PICK2: if (pick_ok && pick_idx != first_q) begin
                face_d     = face_q | pick_bit;
                second_d   = pick_idx;
                pick_val_d = cards[pick_idx];
                moves_d    = (&moves_q) ? moves_q : moves_q + MOVE_W'(1);
                state_d    = EVAL;
            end
            // One cycle between the second pick and the outcome, so match and
            // mismatch appear one edge after face_up.
            EVAL: if (cards[first_q] == cards[second_q]) begin
                matched_d = matched_q | first_bit | second_bit;
                match_d   = 1'b1;
                if ((matched_q | first_bit | second_bit) == 16'hFFFF) begin
                    face_d    = 16'hFFFF;
                    matched_d = 16'hFFFF;
                    state_d   = WIN;
                end else begin
                    state_d = PICK1;
                end
            end else begin
                show_cnt_d = '0;
                state_d    = SHOW;
            end
            SHOW: if (show_cnt_q == CNT_W'(SHOW_CYCLES - 1)) begin
                face_d  = face_q & ~(first_bit | second_bit);
                state_d = PICK1;
            end else begin
                show_cnt_d = show_cnt_q + CNT_W'(1);
            end
            WIN: ;
            default: state_d = IDLE;
        endcase
        if (new_game) begin
            state_d    = REQ;
            layout_d   = layout_q;
            face_d     = '0;
            matched_d  = '0;
            match_d    = 1'b0;
            err_d      = 1'b0;
            show_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            layout_q   <= '0;
            face_q     <= '0;
            matched_q  <= '0;
            pick_val_q <= '0;
            match_q    <= 1'b0;
            err_q      <= 1'b0;
            moves_q    <= '0;
            first_q    <= '0;
            second_q   <= '0;
            show_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            layout_q   <= layout_d;
            face_q     <= face_d;
            matched_q  <= matched_d;
            pick_val_q <= pick_val_d;
            match_q    <= match_d;
            err_q      <= err_d;
            moves_q    <= moves_d;
            first_q    <= first_d;
            second_q   <= second_d;
            show_cnt_q <= show_cnt_d;
        end
    end

    assign shuf_start = (state_q == REQ);
    assign mismatch   = (state_q == SHOW);
    assign game_over  = (state_q == WIN);
    assign busy       = (state_q == REQ) || (state_q == CHECK) || (state_q == SHOW);
    assign face_up    = face_q;
    assign matched    = matched_q;
    assign pick_val   = pick_val_q;
    assign match      = match_q;
    assign layout_err = err_q;
    assign move_count = moves_q;
endmodule
